// File: rtl/common_dffram_pkg.sv
// Shared helpers for the DFF RAM write-port arbiter slice.
// Holds the minimum legal configuration values and the width helpers that
// derive address and requester-index widths from them.
package common_dffram_pkg;

  localparam int MIN_REQ_COUNT = 1;
  localparam int MIN_RAM_DEPTH = 2;

  // Binary word-address width; depths below the minimum still get one bit
  function automatic int addr_width(input int depth);
    return (depth < MIN_RAM_DEPTH) ? 1 : $clog2(depth);
  endfunction

  // Requester index width; a single requester still needs a one-bit pointer
  function automatic int idx_width(input int count);
    return (count <= MIN_REQ_COUNT) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/common_arbiter_rr.sv
// Pure combinational round-robin grant generator.
// Grants the first asserted request at or after ptr, searching cyclically,
// and reports the winner both one-hot and as a binary index.
module common_arbiter_rr
  import common_dffram_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  // Cyclic scan from ptr; the first active request wins
  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/common_dffram_wrport_arbiter.sv
// Round-robin write arbiter and one-entry write stage for port A of the
// 3-address DFF RAM, plus pass-through of read ports B and C.
// Optional feature macro: COMMON_DFFRAM_WRARB_BYPASS_EN forwards the
// in-flight stage write to matching reads on ports B and C.
module common_dffram_wrport_arbiter
  import common_dffram_pkg::*;
#(
  parameter int REQ_COUNT      = 4,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_DEPTH      = 16,
  localparam int ADDR_W = addr_width(RAM_DEPTH),
  localparam int IDX_W  = idx_width(REQ_COUNT)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                hold,
  input  logic [REQ_COUNT-1:0]                req_valid,
  output logic [REQ_COUNT-1:0]                req_ready,
  input  logic [REQ_COUNT*ADDR_W-1:0]         req_addr,
  input  logic [REQ_COUNT*RAM_DATA_WIDTH-1:0] req_data,
  output logic [ADDR_W-1:0]                   ram_addra,
  output logic                                ram_ena,
  output logic                                ram_wea,
  output logic [RAM_DATA_WIDTH-1:0]           ram_dina,
  input  logic [ADDR_W-1:0]                   rd_addrb,
  output logic [RAM_DATA_WIDTH-1:0]           rd_doutb,
  input  logic [ADDR_W-1:0]                   rd_addrc,
  output logic [RAM_DATA_WIDTH-1:0]           rd_doutc,
  output logic [ADDR_W-1:0]                   ram_addrb,
  input  logic [RAM_DATA_WIDTH-1:0]           ram_doutb,
  output logic [ADDR_W-1:0]                   ram_addrc,
  input  logic [RAM_DATA_WIDTH-1:0]           ram_doutc
);

  logic [REQ_COUNT-1:0]      arb_req;
  logic [REQ_COUNT-1:0]      gnt;
  logic [IDX_W-1:0]          gnt_idx;
  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          ptr_next;
  logic                      handshake;
  logic [ADDR_W-1:0]         win_addr;
  logic [RAM_DATA_WIDTH-1:0] win_data;
  logic                      stg_valid;
  logic [ADDR_W-1:0]         stg_addr;
  logic [RAM_DATA_WIDTH-1:0] stg_data;

  // Requests only compete when out of reset and not held
  assign arb_req = (reset && !hold) ? req_valid : '0;

  common_arbiter_rr #(
    .N(REQ_COUNT)
  ) u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The grant is only raised on a valid requester, so any grant is a handshake
  assign req_ready = gnt;
  assign handshake = |gnt;

  // Pointer moves just past the winner, wrapping at the last requester
  assign ptr_next = (int'(gnt_idx) == REQ_COUNT - 1) ? '0 : gnt_idx + IDX_W'(1);

  // AND-OR select of the winning requester's address and data
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (gnt[i]) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
      end
    end
  end

  // Write stage and round-robin pointer; the stage lives exactly one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      stg_valid <= 1'b0;
      stg_addr  <= '0;
      stg_data  <= '0;
      rr_ptr    <= '0;
    end else if (handshake) begin
      stg_valid <= 1'b1;
      stg_addr  <= win_addr;
      stg_data  <= win_data;
      rr_ptr    <= ptr_next;
    end else begin
      stg_valid <= 1'b0;
    end
  end

  assign ram_ena   = stg_valid;
  assign ram_wea   = stg_valid;
  assign ram_addra = stg_addr;
  assign ram_dina  = stg_data;

  assign ram_addrb = rd_addrb;
  assign ram_addrc = rd_addrc;

`ifdef COMMON_DFFRAM_WRARB_BYPASS_EN
  assign rd_doutb = (stg_valid && stg_addr == rd_addrb) ? stg_data : ram_doutb;
  assign rd_doutc = (stg_valid && stg_addr == rd_addrc) ? stg_data : ram_doutc;
`else
  assign rd_doutb = ram_doutb;
  assign rd_doutc = ram_doutc;
`endif

endmodule

// File: tb/tb_common_dffram_wrport_arbiter.sv
// Self-checking bench for common_dffram_wrport_arbiter with a behavioural
// DFF RAM attached. Expected writes go into a scoreboard queue that a
// separate monitor drains whenever port A is enabled.
module tb_common_dffram_wrport_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            hold = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*W-1:0]  req_data = '0;
  logic [AW-1:0]   ram_addra;
  logic            ram_ena;
  logic            ram_wea;
  logic [W-1:0]    ram_dina;
  logic [AW-1:0]   rd_addrb = '0;
  logic [W-1:0]    rd_doutb;
  logic [AW-1:0]   rd_addrc = '0;
  logic [W-1:0]    rd_doutc;
  logic [AW-1:0]   ram_addrb;
  logic [W-1:0]    ram_doutb;
  logic [AW-1:0]   ram_addrc;
  logic [W-1:0]    ram_doutc;

  always #5 clk = ~clk;

  common_dffram_wrport_arbiter #(
    .REQ_COUNT(N),
    .RAM_DATA_WIDTH(W),
    .RAM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .ram_addra(ram_addra), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_dina(ram_dina),
    .rd_addrb(rd_addrb), .rd_doutb(rd_doutb),
    .rd_addrc(rd_addrc), .rd_doutc(rd_doutc),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
    .ram_addrc(ram_addrc), .ram_doutc(ram_doutc)
  );

  // Behavioural DFF RAM: write on port A at the edge, combinational reads
  logic [W-1:0] ram_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
  always @(posedge clk) if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dina;
  assign ram_doutb = ram_mem[ram_addrb];
  assign ram_doutc = ram_mem[ram_addrc];

  // Stimulus values for the next cycle
  logic          drv_rst;
  logic          drv_hold;
  logic [N-1:0]  drv_valid;
  logic [AW-1:0] drv_addr [N];
  logic [W-1:0]  drv_data [N];
  logic [AW-1:0] drv_rdb;
  logic [AW-1:0] drv_rdc;

  // Reference model state
  int            ptr = 0;
  int            exp_w;
  bit            known = 1'b0;
  bit            pend_valid = 1'b0;
  logic [AW-1:0] stg_a = '0;
  logic [W-1:0]  stg_d = '0;
  logic [W-1:0]  committed [DEPTH];
  wr_t           exp_q [$];
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model
  task automatic applyStimulus();
    logic [N-1:0] exp_ready;
    logic [W-1:0] exp_b;
    logic [W-1:0] exp_c;
    @(negedge clk);
    reset     = drv_rst;
    hold      = drv_hold;
    req_valid = drv_valid;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = drv_addr[i];
      req_data[i*W +: W]   = drv_data[i];
    end
    rd_addrb = drv_rdb;
    rd_addrc = drv_rdc;
    #1;
    exp_w = -1;
    if (drv_rst && !drv_hold)
      for (int k = 0; k < N; k++)
        if (exp_w < 0 && drv_valid[(ptr + k) % N]) exp_w = (ptr + k) % N;
    exp_ready = (exp_w >= 0) ? (N'(1) << exp_w) : '0;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    checkOutput("ram_addrb", 64'(ram_addrb), 64'(drv_rdb));
    checkOutput("ram_addrc", 64'(ram_addrc), 64'(drv_rdc));
    if (known) begin
      checkOutput("ram_ena", 64'(ram_ena), 64'(pend_valid));
      checkOutput("ram_wea", 64'(ram_wea), 64'(pend_valid));
      checkOutput("ram_addra", 64'(ram_addra), 64'(stg_a));
      checkOutput("ram_dina", 64'(ram_dina), 64'(stg_d));
      exp_b = committed[drv_rdb];
      exp_c = committed[drv_rdc];
`ifdef COMMON_DFFRAM_WRARB_BYPASS_EN
      if (pend_valid && stg_a == drv_rdb) exp_b = stg_d;
      if (pend_valid && stg_a == drv_rdc) exp_c = stg_d;
`endif
      checkOutput("rd_doutb", 64'(rd_doutb), 64'(exp_b));
      checkOutput("rd_doutc", 64'(rd_doutc), 64'(exp_c));
    end
    @(posedge clk);
    if (known && pend_valid) committed[stg_a] = stg_d;
    if (!drv_rst) begin
      ptr = 0;
      pend_valid = 1'b0;
      stg_a = '0;
      stg_d = '0;
      known = 1'b1;
    end else if (exp_w >= 0) begin
      pend_valid = 1'b1;
      stg_a = drv_addr[exp_w];
      stg_d = drv_data[exp_w];
      exp_q.push_back('{addr: drv_addr[exp_w], data: drv_data[exp_w]});
      ptr = (exp_w + 1) % N;
    end else begin
      pend_valid = 1'b0;
    end
  endtask

  task automatic idle(input int cycles);
    drv_rst = 1'b1;
    drv_hold = 1'b0;
    drv_valid = '0;
    repeat (cycles) applyStimulus();
  endtask

  task automatic doReset(input int cycles);
    drv_rst = 1'b0;
    drv_hold = 1'b0;
    drv_valid = '0;
    repeat (cycles) applyStimulus();
    drv_rst = 1'b1;
  endtask

  // Scoreboard monitor: every enabled port-A cycle must match the next expected write
  always @(negedge clk) begin
    wr_t e;
    if (ram_ena === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addra, ram_dina);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write_addr", 64'(ram_addra), 64'(e.addr));
        checkOutput("write_data", 64'(ram_dina), 64'(e.data));
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) committed[i] = '0;
    for (int i = 0; i < N; i++) begin
      drv_addr[i] = '0;
      drv_data[i] = '0;
    end
    drv_rdb = '0;
    drv_rdc = '0;
    drv_hold = 1'b0;
    drv_valid = '0;
    doReset(2);

    // Single write: requester 2, addr 5, 0xDEADBEEF, then read it on B
    drv_rdb = 4'd5;
    drv_rdc = 4'd5;
    drv_valid = 4'b0100;
    drv_addr[2] = 4'd5;
    drv_data[2] = 32'hDEADBEEF;
    applyStimulus();
    idle(3);

    // Fairness: all valid for 8 cycles from reset
    doReset(1);
    for (int c = 0; c < 8; c++) begin
      drv_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
        drv_addr[i] = AW'(8 + (c % 2));
        drv_data[i] = 32'h100 * (c + 1) + i;
      end
      drv_rdb = 4'd8;
      drv_rdc = 4'd9;
      applyStimulus();
    end
    idle(2);

    // Hold: load a stage from requester 3, then hold with 0 and 3 valid
    doReset(1);
    drv_valid = 4'b1000;
    drv_addr[3] = 4'd10;
    drv_data[3] = 32'hCAFE0003;
    drv_rdb = 4'd10;
    applyStimulus();
    drv_hold = 1'b1;
    drv_valid = 4'b1001;
    drv_addr[0] = 4'd11;
    drv_data[0] = 32'hCAFE0000;
    repeat (3) applyStimulus();
    drv_hold = 1'b0;
    repeat (2) applyStimulus();
    idle(2);

    // Bypass/old-value read on address 3 during the stage cycle
    drv_rdb = 4'd3;
    drv_rdc = 4'd3;
    drv_valid = 4'b0010;
    drv_addr[1] = 4'd3;
    drv_data[1] = 32'h1234;
    applyStimulus();
    idle(2);

    // Reset in the cycle after a grant
    drv_valid = 4'b0100;
    drv_addr[2] = 4'd9;
    drv_data[2] = 32'h0BAD0009;
    drv_rdb = 4'd9;
    applyStimulus();
    doReset(1);
    drv_valid = 4'b0110;
    drv_addr[1] = 4'd12;
    drv_data[1] = 32'h0000C001;
    applyStimulus();
    idle(2);

    // Same-address race on address 7
    drv_rdb = 4'd7;
    drv_rdc = 4'd7;
    drv_valid = 4'b0010;
    drv_addr[1] = 4'd7;
    drv_data[1] = 32'hA;
    applyStimulus();
    drv_valid = 4'b0100;
    drv_addr[2] = 4'd7;
    drv_data[2] = 32'hB;
    applyStimulus();
    idle(3);
    checkOutput("race_final_addr7", 64'(rd_doutb), 64'h0000000B);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      drv_rst = ($urandom_range(0, 49) != 0);
      drv_hold = ($urandom_range(0, 7) == 0);
      drv_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        drv_addr[i] = AW'($urandom_range(0, DEPTH - 1));
        drv_data[i] = $urandom;
      end
      drv_rdb = ($urandom_range(0, 1) == 0) ? stg_a : AW'($urandom_range(0, DEPTH - 1));
      drv_rdc = ($urandom_range(0, 1) == 0) ? stg_a : AW'($urandom_range(0, DEPTH - 1));
      applyStimulus();
    end
    idle(3);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
